// File: rtl/adim_toplayici.sv
// Rotary-dial step collector: counts right steps, then left steps, and commits
// the pair on confirm. Sequence, overflow and inactivity errors abort the entry.
module adim_toplayici #(
  parameter int ZAMAN_ASIMI = 50_000_000,
  parameter int ZS_GENISLIK = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sag_darbe,
  input  logic       sol_darbe,
  input  logic       onayla,
  input  logic       iptal,
  output logic [2:0] sag_adim,
  output logic [1:0] sol_adim,
  output logic       adim_gecerli,
  output logic       yeni_giris,
  output logic       mesgul,
  output logic       hata
);

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] SAG   = 2'd1;
  localparam logic [1:0] SOL   = 2'd2;

  logic [1:0]             r_durum;
  logic [2:0]             r_sag_cnt;
  logic [1:0]             r_sol_cnt;
  logic [ZS_GENISLIK-1:0] r_zs;
  logic                   r_sag_onceki, r_sol_onceki, r_onay_onceki, r_iptal_onceki;
  logic                   r_hazir;
  logic [2:0]             r_sag_adim;
  logic [1:0]             r_sol_adim;
  logic                   r_gecerli, r_yeni, r_hata;

  logic w_sag_e, w_sol_e, w_onay_e, w_iptal_e, w_olay;
  logic w_zaman_doldu, w_hata, w_onay;

  // r_hazir masks the first cycle after reset so levels already high are not events.
  assign w_sag_e   = sag_darbe & ~r_sag_onceki   & r_hazir;
  assign w_sol_e   = sol_darbe & ~r_sol_onceki   & r_hazir;
  assign w_onay_e  = onayla    & ~r_onay_onceki  & r_hazir;
  assign w_iptal_e = iptal     & ~r_iptal_onceki & r_hazir;
  assign w_olay    = w_sag_e | w_sol_e | w_onay_e | w_iptal_e;

  assign w_zaman_doldu = (r_durum != BOSTA) && !w_olay &&
                         (r_zs == ZS_GENISLIK'(ZAMAN_ASIMI - 1));

  assign w_hata = !w_iptal_e && (
                    (w_sag_e && w_sol_e) ||
                    (r_durum == BOSTA && w_sol_e) ||
                    (r_durum == SAG && w_sag_e && r_sag_cnt == 3'd7) ||
                    (r_durum == SOL && w_sag_e) ||
                    (r_durum == SOL && w_sol_e && r_sol_cnt == 2'd3) ||
                    w_zaman_doldu);

  assign w_onay = !w_iptal_e && !w_hata && w_onay_e && (r_durum != BOSTA);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_durum        <= BOSTA;
      r_sag_cnt      <= '0;
      r_sol_cnt      <= '0;
      r_zs           <= '0;
      r_sag_onceki   <= 1'b0;
      r_sol_onceki   <= 1'b0;
      r_onay_onceki  <= 1'b0;
      r_iptal_onceki <= 1'b0;
      r_hazir        <= 1'b0;
      r_sag_adim     <= '0;
      r_sol_adim     <= '0;
      r_gecerli      <= 1'b0;
      r_yeni         <= 1'b0;
      r_hata         <= 1'b0;
    end else begin
      r_sag_onceki   <= sag_darbe;
      r_sol_onceki   <= sol_darbe;
      r_onay_onceki  <= onayla;
      r_iptal_onceki <= iptal;
      r_hazir        <= 1'b1;
      r_yeni         <= 1'b0;
      r_hata         <= 1'b0;

      if (w_olay || r_durum == BOSTA) r_zs <= '0;
      else                            r_zs <= r_zs + 1'b1;

      if (w_iptal_e) begin
        r_durum   <= BOSTA;
        r_sag_cnt <= '0;
        r_sol_cnt <= '0;
        r_gecerli <= 1'b0;
      end else if (w_hata) begin
        r_hata    <= 1'b1;
        r_gecerli <= 1'b0;
        r_durum   <= BOSTA;
        r_sag_cnt <= '0;
        r_sol_cnt <= '0;
      end else if (w_onay) begin
        r_sag_adim <= r_sag_cnt;
        r_sol_adim <= r_sol_cnt;
        r_gecerli  <= 1'b1;
        r_yeni     <= 1'b1;
        r_durum    <= BOSTA;
        r_sag_cnt  <= '0;
        r_sol_cnt  <= '0;
      end else begin
        case (r_durum)
          BOSTA: if (w_sag_e) begin
            r_durum   <= SAG;
            r_sag_cnt <= 3'd1;
            r_gecerli <= 1'b0;
          end
          SAG: begin
            if (w_sag_e) r_sag_cnt <= r_sag_cnt + 3'd1;
            else if (w_sol_e) begin
              r_sol_cnt <= 2'd1;
              r_durum   <= SOL;
            end
          end
          SOL: if (w_sol_e) r_sol_cnt <= r_sol_cnt + 2'd1;
          default: r_durum <= BOSTA;
        endcase
      end
    end
  end

  assign sag_adim     = r_sag_adim;
  assign sol_adim     = r_sol_adim;
  assign adim_gecerli = r_gecerli;
  assign yeni_giris   = r_yeni;
  assign mesgul       = (r_durum != BOSTA);
  assign hata         = r_hata;

endmodule

// File: tb/tb_adim_toplayici.sv
// Bench for adim_toplayici: directed entries plus random step traffic, every
// cycle compared against a behavioural model of the dial-entry rules.
module tb_adim_toplayici;
  localparam int ZA = 20;

  logic       clk = 1'b0;
  logic       rst_n, sag_darbe, sol_darbe, onayla, iptal;
  logic [2:0] sag_adim;
  logic [1:0] sol_adim;
  logic       adim_gecerli, yeni_giris, mesgul, hata;

  adim_toplayici #(.ZAMAN_ASIMI(ZA), .ZS_GENISLIK(5)) dut (
    .clk(clk), .rst_n(rst_n), .sag_darbe(sag_darbe), .sol_darbe(sol_darbe),
    .onayla(onayla), .iptal(iptal), .sag_adim(sag_adim), .sol_adim(sol_adim),
    .adim_gecerli(adim_gecerli), .yeni_giris(yeni_giris), .mesgul(mesgul),
    .hata(hata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];

  // Behavioural model: phase 0 idle, 1 right turns, 2 left turns.
  int  m_phase, m_right, m_left, m_idle;
  bit  m_armed;
  bit  m_prev[4];
  int  m_sag_adim, m_sol_adim;
  bit  m_valid, m_new, m_hata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit s, input bit l,
                                     input bit o, input bit i);
    bit es, el, eo, ei, any, err, commit;
    if (!r) begin
      m_phase = 0; m_right = 0; m_left = 0; m_idle = 0; m_armed = 0;
      for (int k = 0; k < 4; k++) m_prev[k] = 0;
      m_sag_adim = 0; m_sol_adim = 0; m_valid = 0; m_new = 0; m_hata = 0;
      return;
    end
    es = s && !m_prev[0] && m_armed;
    el = l && !m_prev[1] && m_armed;
    eo = o && !m_prev[2] && m_armed;
    ei = i && !m_prev[3] && m_armed;
    m_prev[0] = s; m_prev[1] = l; m_prev[2] = o; m_prev[3] = i;
    m_armed = 1;
    any = es || el || eo || ei;
    m_new = 0; m_hata = 0; err = 0; commit = 0;
    if (ei) begin
      m_phase = 0; m_right = 0; m_left = 0; m_valid = 0;
    end else begin
      if (es && el) err = 1;
      else if (m_phase == 0 && el) err = 1;
      else if (m_phase == 1 && es && m_right == 7) err = 1;
      else if (m_phase == 2 && es) err = 1;
      else if (m_phase == 2 && el && m_left == 3) err = 1;
      else if (m_phase != 0 && !any && m_idle == ZA - 1) err = 1;
      if (err) begin
        m_hata = 1; m_valid = 0; m_phase = 0; m_right = 0; m_left = 0;
      end else if (m_phase == 0) begin
        if (es) begin m_phase = 1; m_right = 1; m_valid = 0; end
      end else if (eo) begin
        m_sag_adim = m_right; m_sol_adim = m_left; m_valid = 1; m_new = 1;
        m_phase = 0; m_right = 0; m_left = 0;
      end else if (es) begin
        m_right++;
      end else if (el) begin
        if (m_phase == 1) begin m_phase = 2; m_left = 1; end
        else m_left++;
      end
    end
    if (any || m_phase == 0) m_idle = 0;
    else m_idle++;
  endfunction

  // One clock: drive levels, advance the model at the edge, compare after it.
  task automatic apply(input bit r, input bit s, input bit l, input bit o, input bit i);
    rst_n = r; sag_darbe = s; sol_darbe = l; onayla = o; iptal = i;
    @(posedge clk);
    model_step(r, s, l, o, i);
    #1;
    chk("sag_adim", 32'(sag_adim), 32'(m_sag_adim));
    chk("sol_adim", 32'(sol_adim), 32'(m_sol_adim));
    chk("adim_gecerli", 32'(adim_gecerli), 32'(m_valid));
    chk("yeni_giris", 32'(yeni_giris), 32'(m_new));
    chk("mesgul", 32'(mesgul), 32'(m_phase != 0));
    chk("hata", 32'(hata), 32'(m_hata));
    if (m_new) exp_q.push_back({3'(m_sag_adim), 2'(m_sol_adim)});
    if (yeni_giris) begin
      if (exp_q.size() == 0) chk("sb_unexpected_commit", 32'(1), 32'(0));
      else chk("sb_commit", 32'({sag_adim, sol_adim}), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(1, 0, 0, 0, 0);
  endtask

  task automatic pulse(input bit s, input bit l, input bit o, input bit i);
    apply(1, s, l, o, i);
    apply(1, 0, 0, 0, 0);
  endtask

  int  lat;
  bit  seen;
  int  quiet;
  bit  rs, ss, ls, os, is_;

  initial begin
    apply(0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0);
    chk("reset_gecerli", 32'(adim_gecerli), 32'(0));
    chk("reset_mesgul", 32'(mesgul), 32'(0));
    idle(2);

    // Normal entry 3 right, 2 left.
    for (int k = 0; k < 3; k++) pulse(1, 0, 0, 0);
    for (int k = 0; k < 2; k++) pulse(0, 1, 0, 0);
    apply(1, 0, 0, 1, 0);
    chk("normal_sag", 32'(sag_adim), 32'(3));
    chk("normal_sol", 32'(sol_adim), 32'(2));
    chk("normal_yeni", 32'(yeni_giris), 32'(1));
    chk("normal_mesgul", 32'(mesgul), 32'(0));
    apply(1, 0, 0, 0, 0);
    chk("yeni_one_cycle", 32'(yeni_giris), 32'(0));

    // Right-only entry.
    for (int k = 0; k < 5; k++) pulse(1, 0, 0, 0);
    apply(1, 0, 0, 1, 0);
    chk("right_only", 32'({sag_adim, sol_adim, adim_gecerli}), 32'({3'd5, 2'd0, 1'b1}));
    idle(1);

    // Right overflow on the 8th step.
    for (int k = 0; k < 7; k++) pulse(1, 0, 0, 0);
    apply(1, 1, 0, 0, 0);
    chk("ovf_sag_hata", 32'({hata, mesgul, adim_gecerli}), 32'({1'b1, 1'b0, 1'b0}));
    chk("ovf_sag_hold", 32'({sag_adim, sol_adim}), 32'({3'd5, 2'd0}));
    idle(1);

    // Left overflow on the 4th left step.
    pulse(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) pulse(0, 1, 0, 0);
    apply(1, 0, 1, 0, 0);
    chk("ovf_sol_hata", 32'(hata), 32'(1));
    idle(1);

    // Sequence error, then simultaneous steps.
    pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(0, 1, 0, 0);
    apply(1, 1, 0, 0, 0);
    chk("seq_hata", 32'(hata), 32'(1));
    idle(1);
    apply(1, 1, 1, 0, 0);
    chk("simul_hata", 32'({hata, mesgul}), 32'({1'b1, 1'b0}));
    idle(1);

    // Timeout latency from the step event.
    apply(1, 1, 0, 0, 0);
    lat = 0; seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      apply(1, 0, 0, 0, 0);
      if (hata) begin seen = 1; lat = k; end
    end
    chk("timeout_seen", 32'(seen), 32'(1));
    chk("timeout_lat", 32'(lat), 32'(ZA));

    // A step on cycle 19 restarts the idle count.
    apply(1, 1, 0, 0, 0);
    idle(18);
    apply(1, 1, 0, 0, 0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      apply(1, 0, 0, 0, 0);
      if (hata) seen = 1;
    end
    chk("timeout_rearm", 32'(seen), 32'(0));
    pulse(0, 0, 0, 1);

    // Cancel and reset mid-entry.
    for (int k = 0; k < 4; k++) pulse(1, 0, 0, 0);
    apply(1, 0, 0, 0, 1);
    chk("cancel", 32'({hata, mesgul}), 32'(0));
    idle(1);
    for (int k = 0; k < 4; k++) pulse(1, 0, 0, 0);
    apply(0, 0, 0, 0, 0);
    chk("reset_mid", 32'({sag_adim, sol_adim, adim_gecerli, yeni_giris, mesgul, hata}), 32'(0));

    // Levels held high across reset release produce no event.
    apply(0, 1, 0, 1, 0);
    apply(1, 1, 0, 1, 0);
    apply(1, 1, 0, 1, 0);
    chk("held_no_event", 32'({mesgul, yeni_giris}), 32'(0));
    idle(2);

    // Random traffic.
    quiet = 0;
    for (int c = 0; c < 5000; c++) begin
      if (quiet > 0) begin
        quiet--;
        apply(1, 0, 0, 0, 0);
      end else begin
        if ($urandom_range(0, 60) == 0) quiet = $urandom_range(15, 25);
        rs  = ($urandom_range(0, 399) != 0);
        ss  = ($urandom_range(0, 2) == 0);
        ls  = ($urandom_range(0, 4) == 0);
        os  = ($urandom_range(0, 12) == 0);
        is_ = ($urandom_range(0, 40) == 0);
        apply(rs, ss, ls, os, is_);
      end
    end
    idle(2);
    chk("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/adim_toplayici.md
Name: adim_toplayici

Overview:
- Upstream stage of the lock comparator. Collects debounced rotary-dial step pulses: right-turn steps first, then left-turn steps.
- On confirm, presents the counts as sag_adim[2:0] and sol_adim[1:0] for the combinational lock-check stage.
- Flags sequence, overflow and timeout errors, and holds the committed entry stable until a new entry begins.

Parameters:
- ZAMAN_ASIMI, 50_000_000: inactivity limit in clock cycles while an entry is in progress (1 s at 50 MHz).
- ZS_GENISLIK, 26: width of the inactivity counter; must satisfy 2^ZS_GENISLIK > ZAMAN_ASIMI.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- sag_darbe  input  1  debounced right-step level; one step per rising edge.
- sol_darbe  input  1  debounced left-step level; one step per rising edge.
- onayla  input  1  confirm level; acts on its rising edge.
- iptal  input  1  cancel level; acts on its rising edge.
- sag_adim  output  3  committed right-step count (registered).
- sol_adim  output  2  committed left-step count (registered).
- adim_gecerli  output  1  level: committed counts are valid.
- yeni_giris  output  1  one-cycle strobe on commit.
- mesgul  output  1  high while in SAG or SOL.
- hata  output  1  one-cycle strobe on any error abort.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Every output is 0.
  - Internal counters are 0, state is BOSTA, edge-detect history registers are 0.
  - Reset mid-entry discards the entry with no hata pulse.
- Edge detect:
  - Each input has a previous-sample register.
  - An event is input=1 with previous=0 at a clk edge.
  - Event effects and registered outputs update at that same edge, i.e. outputs change one clk after the input rises.
- States: BOSTA (idle), SAG (counting right steps), SOL (counting left steps).
- Event priority within one cycle: iptal > error conditions > onayla > steps.
- BOSTA:
  - sag event: sag_cnt=1, go to SAG, adim_gecerli cleared.
  - sol event: hata, stay BOSTA, adim_gecerli cleared.
  - onayla: ignored.
  - iptal: adim_gecerli cleared.
- SAG:
  - sag event: sag_cnt+1. An 8th step (sag_cnt=7) is overflow: hata, return to BOSTA.
  - sol event: sol_cnt=1, go to SOL.
  - onayla: commit.
- SOL:
  - sol event: sol_cnt+1. A 4th step (sol_cnt=3) is overflow: hata, return to BOSTA.
  - sag event: sequence error: hata, return to BOSTA.
  - onayla: commit.
- Simultaneous sag and sol events in any state: hata, return to BOSTA.
- Commit:
  - sag_adim<=sag_cnt, sol_adim<=sol_cnt, adim_gecerli<=1, yeni_giris=1 for one cycle.
  - Counters clear, go to BOSTA.
  - A step event in the same cycle as onayla is discarded.
- iptal in SAG or SOL: counters clear, go to BOSTA, no hata pulse.
- Committed registers:
  - sag_adim/sol_adim hold their last committed values across errors, cancels and new entries until the next commit.
  - adim_gecerli falls on the first sag event from BOSTA, on any hata, or on iptal.
- Timeout:
  - The inactivity counter resets on every event and counts only in SAG/SOL.
  - Reaching ZAMAN_ASIMI-1 while still in SAG/SOL produces hata, counters clear, go to BOSTA.
  - An event arriving on the timeout cycle takes priority; the counter resets.
- Every error path clears sag_cnt/sol_cnt. hata is asserted for exactly one cycle per error.
- An input held high produces only one event. A level already high when reset is released produces no event.

Test Plan:
- Normal entry: 3 sag pulses, 2 sol pulses, onayla -> one clk after onayla rises: sag_adim=3, sol_adim=2, adim_gecerli=1, yeni_giris high 1 cycle, mesgul=0.
- Right-only entry: 5 sag pulses, onayla -> sag_adim=5, sol_adim=0, adim_gecerli=1.
- Overflow: 8 sag pulses -> hata pulse on the 8th, state BOSTA, sag_adim/sol_adim unchanged from the prior commit, adim_gecerli=0. Repeat with 1 sag + 4 sol -> hata on the 4th sol.
- Sequence/simultaneous: 2 sag, 1 sol, 1 sag -> hata on the last sag. Also sag and sol rising the same clk -> hata, mesgul=0.
- Timeout: ZAMAN_ASIMI=20; 1 sag then idle -> hata exactly 20 clk after the sag event. A step on cycle 19 instead -> no hata.
- Reset/cancel: 4 sag then iptal -> no hata, mesgul=0. 4 sag then rst_n=0 for 1 clk -> all outputs 0. onayla held high across reset release -> no commit.
